// File: rtl/regfile_pkg.sv
// Shared sizes and types for the LEGv8 architectural register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_WIDTH-1:0] reg_word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/decoder2_4.sv
// 2:4 one-hot decoder with enable; output is all-zero when disabled.
module decoder2_4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_y
);

  assign o_y = i_en ? (4'b0001 << i_sel) : 4'b0000;

endmodule

// File: rtl/decoder3_8.sv
// 3:8 one-hot decoder with enable; i_i0 is the select MSB, i_i2 the LSB.
module decoder3_8 (
  input  logic       i_en,
  input  logic       i_i0,
  input  logic       i_i1,
  input  logic       i_i2,
  output logic [7:0] o_y
);

  assign o_y = i_en ? (8'b0000_0001 << {i_i0, i_i1, i_i2}) : 8'b0000_0000;

endmodule

// File: rtl/decoder5_32.sv
// 5:32 write-enable decoder: a gated 2:4 stage selects one of four 3:8 decoders.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic        i_en,
  input  reg_idx_t    i_sel,
  output logic [31:0] o_y
);

  logic [3:0] w_grp;

  // Gating at the first stage keeps X on i_sel from leaking out while i_en=0.
  decoder2_4 u_dec_hi (
    .i_en  (i_en),
    .i_sel (i_sel[4:3]),
    .o_y   (w_grp)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lo
    decoder3_8 u_dec_lo (
      .i_en (w_grp[g]),
      .i_i0 (i_sel[2]),
      .i_i1 (i_sel[1]),
      .i_i2 (i_sel[0]),
      .o_y  (o_y[g*8 +: 8])
    );
  end

endmodule

// File: rtl/dff_en.sv
// Register with synchronous active-low clear and load enable.
module dff_en #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file, two async read ports, one sync write port; X31 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_32x64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  import regfile_pkg::*;

  logic [31:0]           w_wr_en;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  decoder5_32 u_dec (
    .i_en  (RegWrite),
    .i_sel (WriteRegister),
    .o_y   (w_wr_en)
  );

  // X31 has no storage; its enable line is deliberately left unused.
  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
    dff_en #(
      .WIDTH (DATA_WIDTH)
    ) u_reg (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_en    (w_wr_en[i]),
      .i_d     (WriteData),
      .o_q     (w_regs[i])
    );
  end
  assign w_regs[NUM_REGS-1] = '0;

  assign w_rd1 = w_regs[ReadRegister1];
  assign w_rd2 = w_regs[ReadRegister2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd     = RegWrite && reset_n && (WriteRegister != ZERO_REG);
  assign ReadData1 = (w_fwd && (ReadRegister1 == WriteRegister)) ? WriteData : w_rd1;
  assign ReadData2 = (w_fwd && (ReadRegister2 == WriteRegister)) ? WriteData : w_rd2;
`else
  assign ReadData1 = w_rd1;
  assign ReadData2 = w_rd2;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64; expected read data is queued from a reference model.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  logic [63:0] mdl [32];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_32x64 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read value, including same-cycle forwarding when that build option is on.
  function automatic logic [63:0] model_rd(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite === 1'b1 && reset_n === 1'b1 && WriteRegister !== 5'd31 &&
        idx === WriteRegister)
      return WriteData;
`endif
    if (reset_n !== 1'b1) return 64'h0;
    return mdl[idx];
  endfunction

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    exp_q.push_back(model_rd(a1));
    exp_q.push_back(model_rd(a2));
    #1;
    check({tag, "_p1"}, ReadData1, exp_q.pop_front());
    check({tag, "_p2"}, ReadData2, exp_q.pop_front());
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] data);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    tick();
    if (reset_n === 1'b1 && idx != 5'd31) mdl[idx] = data;
    RegWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    reset_n       = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    // Decoder: one-hot when enabled, zero when disabled even with X select.
    for (int k = 0; k < 32; k++) begin
      RegWrite      = 1'b1;
      WriteRegister = 5'(k);
      #1;
      check($sformatf("dec_%0d", k), {32'h0, dut.w_wr_en}, {32'h0, 32'h1 << k});
    end
    RegWrite      = 1'b0;
    WriteRegister = 5'bxxxxx;
    #1;
    check("dec_off", {32'h0, dut.w_wr_en}, 64'h0);
    WriteRegister = 5'd0;
    tick();
    tick();
    rd("rst_init", 5'd0, 5'd17);

    // Reset clears stored data and wins over a coincident write.
    reset_n = 1'b1;
    wr(5'd5, 64'hDEAD_BEEF_0000_0001);
    rd("pre_rst", 5'd5, 5'd0);
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    wr(5'd0, 64'h99);
    RegWrite      = 1'b1;
    WriteRegister = 5'd0;
    WriteData     = 64'h77;
    rd("in_rst", 5'd5, 5'd0);
    RegWrite = 1'b0;
    reset_n  = 1'b1;
    tick();
    rd("post_rst", 5'd5, 5'd0);

    // Fill X0..X30 and read everything back on both ports.
    for (int k = 0; k < 31; k++) wr(5'(k), 64'h0101_0101_0101_0101 * 64'(k));
    for (int k = 0; k < 32; k++) rd($sformatf("all_%0d", k), 5'(k), 5'(31 - k));

    // Writes to XZR are discarded and never forwarded.
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    rd("xzr_same", 5'd31, 5'd0);
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 32; k++) rd($sformatf("xzr_%0d", k), 5'(k), 5'(k));

    // Disabled writes, including X address/data, leave state unchanged.
    wr(5'd7, 64'hA5A5);
    WriteRegister = 5'd7;
    WriteData     = 64'h1234;
    tick();
    rd("wdis", 5'd7, 5'd6);
    WriteRegister = 5'bxxxxx;
    WriteData     = 64'hxxxx_xxxx_xxxx_xxxx;
    tick();
    rd("wx", 5'd7, 5'd8);
    for (int k = 0; k < 31; k++) rd($sformatf("wx_%0d", k), 5'(k), 5'(k));

    // Same-cycle write/read of X3.
    wr(5'd3, 64'h11);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h22;
`ifdef REGFILE_BYPASS_EN
    check("haz_model", model_rd(5'd3), 64'h22);
`else
    check("haz_model", model_rd(5'd3), 64'h11);
`endif
    rd("haz_pre", 5'd3, 5'd3);
    tick();
    mdl[3]   = 64'h22;
    RegWrite = 1'b0;
    rd("haz_post", 5'd3, 5'd3);

    check("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
